ball_motion: RTL and testbench

- Owns the ball: holds ballx/bally, steps it one pixel per axis on a divided movement tick, and bounces it off walls, the paddle and bricks.
- Consumes the OR-reduced topbotcol / LRcol pulses from all brick instances and drives the ballx/bally bus back into every brick. It is both upstream and downstream of the brick stage.
- Detects a ball lost past the bottom edge, counts lives, and flags game over.

---
 rtl/ball_motion.sv | 136 +++++++++++++
 tb/tb_ball_motion.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball position/direction owner: steps the ball on a divided tick, bounces it off
// walls, paddle and bricks, and tracks lives through loss and game over.
module ball_motion #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int START_X  = 320,
    parameter int START_Y  = 400,
    parameter int PADDLE_Y = 440,
    parameter int PADDLE_W = 80,
    parameter int MOVE_DIV = 416666,
    parameter int LIVES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       topbotcol,
    input  logic       LRcol,
    input  logic [9:0] paddlex,
    output logic [9:0] ballx,
    output logic [9:0] bally,
    output logic       dirx,
    output logic       diry,
    output logic       moving,
    output logic [1:0] lives,
    output logic       ball_lost,
    output logic       game_over,
    output logic [1:0] state_dbg
);
    localparam int CW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MOVE_DIV - 1);
    localparam logic [9:0] X_MAX   = 10'(SCREEN_W - 1);
    localparam logic [9:0] Y_MAX   = 10'(SCREEN_H - 1);
    localparam logic [9:0] X_START = 10'(START_X);
    localparam logic [9:0] Y_START = 10'(START_Y);
    localparam logic [9:0] PAD_ROW = 10'(PADDLE_Y - 1);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, LOST = 2'd2, OVER = 2'd3} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pt, pl;
    logic          step, ex, ey, on_paddle, lose;
    logic [10:0]   paddle_end;

    assign state_dbg  = state;
    assign step       = (cnt == CNT_LAST);
    // 11-bit so a paddle near the right edge cannot wrap its span
    assign paddle_end = {1'b0, paddlex} + 11'(PADDLE_W);
    assign on_paddle  = ({1'b0, ballx} >= {1'b0, paddlex}) && ({1'b0, ballx} < paddle_end);

    // Wall overrides beat brick flips; the paddle only reflects a descending ball
    always_comb begin
        ex = dirx ^ (pl | LRcol);
        ey = diry ^ (pt | topbotcol);
        if (ballx == 10'd0)
            ex = 1'b1;
        else if (ballx == X_MAX)
            ex = 1'b0;
        if (bally == 10'd0)
            ey = 1'b1;
        if (ey && (bally == PAD_ROW) && on_paddle)
            ey = 1'b0;
        lose = ey && (bally == Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ballx     <= X_START;
            bally     <= Y_START;
            dirx      <= 1'b1;
            diry      <= 1'b0;
            moving    <= 1'b0;
            lives     <= LIVES_INIT;
            ball_lost <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            pt        <= 1'b0;
            pl        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= MOVE;
                        moving <= 1'b1;
                        cnt    <= '0;
                    end
                end
                MOVE: begin
                    if (step) begin
                        cnt <= '0;
                        pt  <= 1'b0;
                        pl  <= 1'b0;
                        if (lose) begin
                            state     <= LOST;
                            moving    <= 1'b0;
                            ball_lost <= 1'b1;
                        end else begin
                            ballx <= ex ? ballx + 10'd1 : ballx - 10'd1;
                            bally <= ey ? bally + 10'd1 : bally - 10'd1;
                            dirx  <= ex;
                            diry  <= ey;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Sticky: repeated pulses within one interval flip an axis once
                        if (topbotcol)
                            pt <= 1'b1;
                        if (LRcol)
                            pl <= 1'b1;
                    end
                end
                LOST: begin
                    ball_lost <= 1'b0;
                    lives     <= lives - 2'd1;
                    pt        <= 1'b0;
                    pl        <= 1'b0;
                    ballx     <= X_START;
                    bally     <= Y_START;
                    dirx      <= 1'b1;
                    diry      <= 1'b0;
                    if (lives == 2'd1) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    // OVER holds everything until reset
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: trajectory table plus hand-written brick,
// loss, game-over and reset sequences, all with hand-computed expectations.
module tb_ball_motion;
  logic       clk = 1'b0;
  logic       rst, start, topbotcol, LRcol;
  logic [9:0] paddlex;
  logic [9:0] ballx, bally;
  logic       dirx, diry, moving, ball_lost, game_over;
  logic [1:0] lives, state_dbg;

  int errors = 0;
  int checks = 0;

  ball_motion #(.MOVE_DIV(4), .LIVES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .topbotcol(topbotcol), .LRcol(LRcol),
    .paddlex(paddlex), .ballx(ballx), .bally(bally), .dirx(dirx), .diry(diry),
    .moving(moving), .lives(lives), .ball_lost(ball_lost), .game_over(game_over),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         steps;
    logic       tb;
    logic       lr;
    logic [9:0] px;
    int         ex;
    int         ey;
    logic       edx;
    logic       edy;
  } seg_t;

  seg_t tbl[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_ball(input string name, input int x, input int y, input int dx, input int dy);
    chk({name, ".x"}, int'(ballx), x);
    chk({name, ".y"}, int'(bally), y);
    chk({name, ".dirx"}, int'(dirx), dx);
    chk({name, ".diry"}, int'(diry), dy);
  endtask

  // Assumes the tick counter is 0; the collision inputs are applied on the step edge only
  task automatic run_step(input logic tb, input logic lr);
    repeat (3) tick();
    topbotcol = tb;
    LRcol     = lr;
    tick();
    topbotcol = 1'b0;
    LRcol     = 1'b0;
  endtask

  task automatic serve();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // steps, tb-on-step, lr-on-step, paddlex, expected x, y, dirx, diry
    tbl[0]  = '{1,   1'b1, 1'b1, 10'd0,   322, 400, 1'b1, 1'b0};  // corner hit
    tbl[1]  = '{1,   1'b0, 1'b0, 10'd0,   323, 399, 1'b1, 1'b0};
    tbl[2]  = '{316, 1'b0, 1'b0, 10'd0,   639, 83,  1'b1, 1'b0};
    tbl[3]  = '{1,   1'b0, 1'b1, 10'd0,   638, 82,  1'b0, 1'b0};  // right wall with LRcol
    tbl[4]  = '{82,  1'b0, 1'b0, 10'd0,   556, 0,   1'b0, 1'b0};
    tbl[5]  = '{1,   1'b0, 1'b0, 10'd0,   555, 1,   1'b0, 1'b1};  // top wall
    tbl[6]  = '{438, 1'b0, 1'b0, 10'd117, 117, 439, 1'b0, 1'b1};
    tbl[7]  = '{1,   1'b0, 1'b0, 10'd117, 116, 438, 1'b0, 1'b0};  // paddle left edge hit
    tbl[8]  = '{116, 1'b0, 1'b0, 10'd117, 0,   322, 1'b0, 1'b0};
    tbl[9]  = '{1,   1'b0, 1'b0, 10'd117, 1,   321, 1'b1, 1'b0};  // left wall
    tbl[10] = '{1,   1'b1, 1'b0, 10'd400, 2,   322, 1'b1, 1'b1};
    tbl[11] = '{117, 1'b0, 1'b0, 10'd400, 119, 439, 1'b1, 1'b1};
    tbl[12] = '{1,   1'b0, 1'b0, 10'd400, 120, 440, 1'b1, 1'b1};  // paddle miss
    tbl[13] = '{39,  1'b0, 1'b0, 10'd400, 159, 479, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; topbotcol = 1'b0; LRcol = 1'b0; paddlex = 10'd0;
    repeat (2) tick();
    chk_ball("reset", 320, 400, 1, 0);
    chk("reset.moving", int'(moving), 0);
    chk("reset.lives", int'(lives), 2);
    chk("reset.ball_lost", int'(ball_lost), 0);
    chk("reset.game_over", int'(game_over), 0);
    chk("reset.state", int'(state_dbg), 0);
    rst = 1'b0;
    tick();
    chk("idle.moving", int'(moving), 0);

    // Serve: moving immediately, first step four cycles later
    serve();
    chk("serve.moving", int'(moving), 1);
    chk("serve.state", int'(state_dbg), 1);
    repeat (3) tick();
    chk_ball("pre_step", 320, 400, 1, 0);
    tick();
    chk_ball("step1", 321, 399, 1, 0);

    // Two topbotcol pulses in one interval: exactly one flip at the step
    topbotcol = 1'b1; tick();
    topbotcol = 1'b0; tick();
    topbotcol = 1'b1; tick();
    topbotcol = 1'b0;
    chk("tb_sticky.hold_diry", int'(diry), 0);
    chk("tb_sticky.hold_y", int'(bally), 399);
    tick();
    chk_ball("tb_sticky", 322, 400, 1, 1);

    // LRcol held for two cycles: one x flip, y flag already cleared
    LRcol = 1'b1; tick(); tick();
    LRcol = 1'b0; tick(); tick();
    chk_ball("lr_sticky", 321, 401, 0, 1);

    for (int i = 0; i < 14; i++) begin
      paddlex = tbl[i].px;
      for (int k = 0; k < tbl[i].steps - 1; k++) run_step(1'b0, 1'b0);
      run_step(tbl[i].tb, tbl[i].lr);
      chk_ball($sformatf("seg%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].edx), int'(tbl[i].edy));
    end

    // First loss: position held for the LOST cycle, then reload into IDLE
    run_step(1'b0, 1'b0);
    chk("loss1.ball_lost", int'(ball_lost), 1);
    chk("loss1.moving", int'(moving), 0);
    chk("loss1.state", int'(state_dbg), 2);
    chk("loss1.x", int'(ballx), 159);
    chk("loss1.y", int'(bally), 479);
    tick();
    chk("loss1.pulse_end", int'(ball_lost), 0);
    chk("loss1.lives", int'(lives), 1);
    chk("loss1.state_idle", int'(state_dbg), 0);
    chk("loss1.game_over", int'(game_over), 0);
    chk_ball("loss1.reload", 320, 400, 1, 0);
    repeat (3) tick();
    chk("idle_hold.x", int'(ballx), 320);

    // Second ball: flip down at once, just miss the paddle's right edge
    paddlex = 10'd279;
    serve();
    run_step(1'b1, 1'b0);
    chk_ball("serve2", 321, 401, 1, 1);
    repeat (38) run_step(1'b0, 1'b0);
    chk_ball("serve2.row", 359, 439, 1, 1);
    run_step(1'b0, 1'b0);
    chk_ball("serve2.miss", 360, 440, 1, 1);
    repeat (39) run_step(1'b0, 1'b0);
    chk_ball("serve2.bottom", 399, 479, 1, 1);
    run_step(1'b0, 1'b0);
    chk("loss2.ball_lost", int'(ball_lost), 1);
    tick();
    chk("loss2.lives", int'(lives), 0);
    chk("loss2.game_over", int'(game_over), 1);
    chk("loss2.state", int'(state_dbg), 3);
    chk("loss2.pulse_end", int'(ball_lost), 0);

    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    chk("over.moving", int'(moving), 0);
    chk("over.game_over", int'(game_over), 1);
    chk("over.state", int'(state_dbg), 3);
    chk("over.lives", int'(lives), 0);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_over.lives", int'(lives), 2);
    chk("rst_over.game_over", int'(game_over), 0);
    chk("rst_over.state", int'(state_dbg), 0);

    // Reset in the middle of MOVE
    serve();
    repeat (6) tick();
    chk("mid.x", int'(ballx), 321);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_ball("mid_rst", 320, 400, 1, 0);
    chk("mid_rst.moving", int'(moving), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
